// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its program ROM and the datapath.
// Signal names keep the original port names of the flat module.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
);
  logic                      i_run;
  logic [OPC_W+ADDR_W-1:0]   i_rom_data;
  logic                      i_flag_carry;
  logic                      i_flag_zero;
  logic [ADDR_W-1:0]         o_rom_addr;
  logic                      o_rom_enable;
  logic [OPC_W+ADDR_W-1:0]   o_ir;
  logic [2:0]                o_step;
  logic [10:0]               o_ctrl;
  logic                      o_halted;

  modport master (
    input  i_run, i_rom_data, i_flag_carry, i_flag_zero,
    output o_rom_addr, o_rom_enable, o_ir, o_step, o_ctrl, o_halted
  );

  modport slave (
    output i_run, i_rom_data, i_flag_carry, i_flag_zero,
    input  o_rom_addr, o_rom_enable, o_ir, o_step, o_ctrl, o_halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC, instruction register and T-state sequencer for the 16x8 program ROM;
// decodes (step, opcode) into a Moore control word for the datapath.
module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fetch_sequencer_if.master bus
);
  localparam int IR_W = OPC_W + ADDR_W;

  localparam logic [10:0] C_MI = 11'h001;
  localparam logic [10:0] C_RI = 11'h002;
  localparam logic [10:0] C_RO = 11'h004;
  localparam logic [10:0] C_IO = 11'h008;
  localparam logic [10:0] C_AI = 11'h010;
  localparam logic [10:0] C_AO = 11'h020;
  localparam logic [10:0] C_EO = 11'h040;
  localparam logic [10:0] C_SU = 11'h080;
  localparam logic [10:0] C_BI = 11'h100;
  localparam logic [10:0] C_OI = 11'h200;
  localparam logic [10:0] C_FI = 11'h400;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  // Encodings double as the externally visible step number.
  typedef enum logic [2:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    HALTED = 3'd7
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [IR_W-1:0]   ir, ir_nx;
  logic              rom_enable;
  logic [10:0]       ctrl;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = ir[IR_W-1:ADDR_W];
  assign operand = ir[ADDR_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= T0;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_nx      = ir;
    rom_enable = 1'b0;
    ctrl       = '0;
    case (state)
      T0: begin
        if (bus.i_run) state_nx = T1;
      end
      T1: begin
        rom_enable = 1'b1;
        ir_nx      = bus.i_rom_data;
        pc_nx      = pc + ADDR_W'(1);
        state_nx   = T2;
      end
      T2: begin
        state_nx = (opcode == OP_HLT) ? HALTED : T3;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IO | C_MI;
          OP_LDI:                         ctrl = C_IO | C_AI;
          OP_OUT:                         ctrl = C_AO | C_OI;
          default:                        ctrl = '0;
        endcase
        // PC already holds the incremented value; a taken jump replaces it.
        if ((opcode == OP_JMP) ||
            (opcode == OP_JC && bus.i_flag_carry) ||
            (opcode == OP_JZ && bus.i_flag_zero))
          pc_nx = operand;
      end
      T3: begin
        state_nx = T4;
        case (opcode)
          OP_LDA:         ctrl = C_RO | C_AI;
          OP_ADD, OP_SUB: ctrl = C_RO | C_BI;
          OP_STA:         ctrl = C_AO | C_RI;
          default:        ctrl = '0;
        endcase
      end
      T4: begin
        state_nx = T0;
        case (opcode)
          OP_ADD:  ctrl = C_EO | C_AI | C_FI;
          OP_SUB:  ctrl = C_EO | C_SU | C_AI | C_FI;
          default: ctrl = '0;
        endcase
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = T0;
    endcase
  end

  assign bus.o_rom_addr   = pc;
  assign bus.o_rom_enable = rom_enable;
  assign bus.o_ir         = ir;
  assign bus.o_step       = state;
  assign bus.o_ctrl       = ctrl;
  assign bus.o_halted     = (state == HALTED);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model
// with a registered ROM model, directed scenarios plus random programs.
module tb_fetch_sequencer;
  localparam logic [10:0] MI = 11'h001, RI = 11'h002, RO = 11'h004, IO = 11'h008;
  localparam logic [10:0] AI = 11'h010, AO = 11'h020, EO = 11'h040, SU = 11'h080;
  localparam logic [10:0] BI = 11'h100, OI = 11'h200, FI = 11'h400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(4), .OPC_W(4)) bus ();
  fetch_sequencer #(.ADDR_W(4), .OPC_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [7:0] code [16];
  logic [7:0] rom_q = '0;
  always @(posedge clk) rom_q <= code[bus.o_rom_addr];
  assign bus.i_rom_data = rom_q;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [3:0] m_pc;
  bit m_halted;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {step, enable, ctrl, addr, halted}
  function automatic logic [19:0] obs();
    return {bus.o_step, bus.o_rom_enable, bus.o_ctrl, bus.o_rom_addr, bus.o_halted};
  endfunction

  // Microcode table: control word for opcode op in T2/T3/T4 (t = 0/1/2).
  function automatic logic [10:0] mc(input logic [3:0] op, input int t);
    logic [10:0] s [3];
    s[0] = '0; s[1] = '0; s[2] = '0;
    case (op)
      4'h1: begin s[0] = IO | MI; s[1] = RO | AI; end
      4'h2: begin s[0] = IO | MI; s[1] = RO | BI; s[2] = EO | AI | FI; end
      4'h3: begin s[0] = IO | MI; s[1] = RO | BI; s[2] = EO | SU | AI | FI; end
      4'h4: begin s[0] = IO | MI; s[1] = AO | RI; end
      4'h5: s[0] = IO | AI;
      4'hE: s[0] = AO | OI;
      default: ;
    endcase
    return s[t];
  endfunction

  task automatic fill_code(input logic [7:0] v);
    for (int i = 0; i < 16; i++) code[i] = v;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.i_run = 1'b1;
    bus.i_flag_carry = 1'b0;
    bus.i_flag_zero = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_pc = '0;
    m_halted = 1'b0;
  endtask

  // Executes one instruction from T0 and checks every cycle against the model.
  task automatic run_instr(input bit rnd, input bit c, input bit z);
    logic [7:0] ins;
    logic [3:0] op, pc1, npc;
    bit cf, zf;
    ins = code[m_pc];
    op  = ins[7:4];
    pc1 = m_pc + 4'd1;
    checks++;
    if (obs() !== {3'd0, 1'b0, 11'h0, m_pc, 1'b0}) begin
      failures++; $display("FAIL t0 pc=%0d got=%h exp=%h", m_pc, obs(), {3'd0, 1'b0, 11'h0, m_pc, 1'b0});
    end
    tick();
    checks++;
    if (obs() !== {3'd1, 1'b1, 11'h0, m_pc, 1'b0}) begin
      failures++; $display("FAIL t1 pc=%0d got=%h exp=%h", m_pc, obs(), {3'd1, 1'b1, 11'h0, m_pc, 1'b0});
    end
    tick();
    cf = rnd ? 1'($urandom_range(1)) : c;
    zf = rnd ? 1'($urandom_range(1)) : z;
    bus.i_flag_carry = cf;
    bus.i_flag_zero = zf;
    checks++;
    if ({bus.o_ir, obs()} !== {ins, 3'd2, 1'b0, mc(op, 0), pc1, 1'b0}) begin
      failures++; $display("FAIL t2 ins=%h got=%h exp=%h", ins, {bus.o_ir, obs()}, {ins, 3'd2, 1'b0, mc(op, 0), pc1, 1'b0});
    end
    npc = pc1;
    if (op == 4'h6 || (op == 4'h7 && cf) || (op == 4'h8 && zf)) npc = ins[3:0];
    tick();
    if (op == 4'hF) begin
      checks++;
      if (obs() !== {3'd7, 1'b0, 11'h0, pc1, 1'b1}) begin
        failures++; $display("FAIL halt_entry got=%h exp=%h", obs(), {3'd7, 1'b0, 11'h0, pc1, 1'b1});
      end
      m_halted = 1'b1;
      return;
    end
    checks++;
    if (obs() !== {3'd3, 1'b0, mc(op, 1), npc, 1'b0}) begin
      failures++; $display("FAIL t3 ins=%h got=%h exp=%h", ins, obs(), {3'd3, 1'b0, mc(op, 1), npc, 1'b0});
    end
    tick();
    checks++;
    if (obs() !== {3'd4, 1'b0, mc(op, 2), npc, 1'b0}) begin
      failures++; $display("FAIL t4 ins=%h got=%h exp=%h", ins, obs(), {3'd4, 1'b0, mc(op, 2), npc, 1'b0});
    end
    tick();
    m_pc = npc;
  endtask

  task automatic test_reset;
    fill_code(8'h00);
    rst_n = 1'b0;
    bus.i_run = 1'b1;
    bus.i_flag_carry = 1'b0;
    bus.i_flag_zero = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.o_ir, obs()} !== 28'h0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", {bus.o_ir, obs()}, 28'h0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs() !== {3'd1, 1'b1, 11'h0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", obs(), {3'd1, 1'b1, 11'h0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_ldi;
    fill_code(8'h00);
    code[0] = 8'h5A;
    do_reset();
    tick();
    checks++;
    if (obs() !== {3'd1, 1'b1, 11'h0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL ldi_t1 got=%h exp=%h", obs(), {3'd1, 1'b1, 11'h0, 4'd0, 1'b0});
    end
    tick();
    checks++;
    if ({bus.o_ir, obs()} !== {8'h5A, 3'd2, 1'b0, 11'h018, 4'd1, 1'b0}) begin
      failures++; $display("FAIL ldi_t2 got=%h exp=%h", {bus.o_ir, obs()}, {8'h5A, 3'd2, 1'b0, 11'h018, 4'd1, 1'b0});
    end
    for (int t = 3; t <= 4; t++) begin
      tick();
      checks++;
      if (obs() !== {3'(t), 1'b0, 11'h0, 4'd1, 1'b0}) begin
        failures++; $display("FAIL ldi_t%0d got=%h exp=%h", t, obs(), {3'(t), 1'b0, 11'h0, 4'd1, 1'b0});
      end
    end
  endtask

  task automatic test_nop_wrap;
    fill_code(8'h00);
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_jumps;
    logic [7:0] ops [2];
    ops[0] = 8'h79;
    ops[1] = 8'h89;
    for (int j = 0; j < 2; j++) begin
      for (int f = 0; f < 2; f++) begin
        fill_code(8'h00);
        code[2] = ops[j];
        do_reset();
        run_instr(1'b0, 1'b0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0);
        run_instr(1'b0, j == 0 ? 1'(f) : 1'(1 - f), j == 1 ? 1'(f) : 1'(1 - f));
        run_instr(1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_add_reset;
    fill_code(8'h2E);
    do_reset();
    tick();
    tick();
    checks++;
    if (bus.o_ctrl !== 11'h009) begin
      failures++; $display("FAIL add_t2 got=%h exp=%h", bus.o_ctrl, 11'h009);
    end
    tick();
    checks++;
    if (bus.o_ctrl !== (RO | BI)) begin
      failures++; $display("FAIL add_t3 got=%h exp=%h", bus.o_ctrl, RO | BI);
    end
    tick();
    checks++;
    if (bus.o_ctrl !== 11'h450) begin
      failures++; $display("FAIL add_t4 got=%h exp=%h", bus.o_ctrl, 11'h450);
    end
    repeat (4) tick();
    checks++;
    if (obs() !== {3'd3, 1'b0, RO | BI, 4'd2, 1'b0}) begin
      failures++; $display("FAIL add2_t3 got=%h exp=%h", obs(), {3'd3, 1'b0, RO | BI, 4'd2, 1'b0});
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs() !== {3'd0, 1'b0, 11'h0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL reset_mid_instr got=%h exp=%h", obs(), {3'd0, 1'b0, 11'h0, 4'd0, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_halt;
    fill_code(8'h00);
    code[0] = 8'hF0;
    do_reset();
    run_instr(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      bus.i_run = 1'($urandom_range(1));
      bus.i_flag_carry = 1'($urandom_range(1));
      bus.i_flag_zero = 1'($urandom_range(1));
      tick();
      checks++;
      if ({bus.o_ir, obs()} !== {8'hF0, 3'd7, 1'b0, 11'h0, 4'd1, 1'b1}) begin
        failures++; $display("FAIL halt_hold cyc=%0d got=%h exp=%h", i, {bus.o_ir, obs()}, {8'hF0, 3'd7, 1'b0, 11'h0, 4'd1, 1'b1});
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (obs() !== {3'd0, 1'b0, 11'h0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL halt_exit got=%h exp=%h", obs(), {3'd0, 1'b0, 11'h0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_run_hold;
    fill_code(8'h00);
    do_reset();
    bus.i_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 11'h0, 4'd0, 1'b0}) begin
        failures++; $display("FAIL run_hold cyc=%0d got=%h exp=%h", i, obs(), 20'h0);
      end
    end
    bus.i_run = 1'b1;
    tick();
    bus.i_run = 1'b0;
    checks++;
    if (obs() !== {3'd1, 1'b1, 11'h0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL run_resume got=%h exp=%h", obs(), {3'd1, 1'b1, 11'h0, 4'd0, 1'b0});
    end
    repeat (3) tick();
    checks++;
    if (bus.o_step !== 3'd4) begin
      failures++; $display("FAIL run_drop_completes got=%0d exp=4", bus.o_step);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs() !== {3'd0, 1'b0, 11'h0, 4'd1, 1'b0}) begin
        failures++; $display("FAIL run_drop_stop cyc=%0d got=%h exp=%h", i, obs(), {3'd0, 1'b0, 11'h0, 4'd1, 1'b0});
      end
    end
  endtask

  task automatic test_random;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) code[i] = 8'($urandom);
      do_reset();
      for (int k = 0; k < 40 && !m_halted; k++) run_instr(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.i_run = 1'b0;
    bus.i_flag_carry = 1'b0;
    bus.i_flag_zero = 1'b0;
    test_reset();
    test_ldi();
    test_nop_wrap();
    test_jumps();
    test_add_reset();
    test_halt();
    test_run_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
